seq_ctrl_unit: RTL and testbench
================================

Name: seq_ctrl_unit

Overview:
Clocked, parametrised hardwired controller for the teaching CPU.
- Generates its own W1/W2/W3 beats and run/halt flag; no external beat inputs.
- Decodes console mode, phase and opcode into datapath strobes.
- Adds a generalised register-file console (REG_N registers) and optional single-step.

Parameters:
REG_N, 4, number of general registers reachable from console modes (power of 2, 2..16)
RSEL_W, 2, register select width; must equal log2(REG_N)

Ports:
t3  input  1  clock; all state updates on rising edge
clr  input  1  reset, asynchronous, active-high
qd  input  1  start pulse, synchronous, one cycle
sw  input  3  console mode {swc,swb,swa}
ir  input  4  opcode field IR[7:4]
c  input  1  carry flag
z  input  1  zero flag
w  output  3  one-hot beat {W3,W2,W1}
st0  output  1  phase flag
halted  output  1  1 when not running
drw, memw, lpc, lar, pcinc, pcadd, arinc, selctl, lir, ldz, ldc, cin, m, abus, sbus, mbus, short, long, stop  output  1 each  datapath/sequencer strobes
s  output  4  ALU function
sel_a  output  RSEL_W  A-port / write register select
sel_b  output  RSEL_W  B-port register select

Behaviour:
- Reset (clr=1, asynchronous): w=001, st0=0, halted=1, reg_idx=0, mode=000. All strobes, s, sel_a and sel_b = 0. clr beats qd.
- All strobes are combinational from (mode, st0, w, ir, c, z, reg_idx), gated to 0 while halted.
- Start: qd while halted latches sw into mode and clears halted. If the latched mode differs from the previous mode, st0 and reg_idx clear to 0. qd while running is ignored; sw is ignored while running.
- Beat sequencing (running only), at each t3 edge:
  - w=001 with short=1: stays 001.
  - w=010 with long=0: returns to 001.
  - w=100: returns to 001.
  - Otherwise: shifts left.
- Halt: halted sets at the edge ending any beat with stop=1. w then returns to 001 as normal.
- Mode 000, run program:
  - st0=0, W1: sbus, lpc, short, stop; st0 then sets to 1.
  - st0=1, W1: lir, pcinc.
  - ADD 0001, W2: s=1001, m=0, cin=1, abus, drw, ldz, ldc.
  - SUB 0010, W2: s=0110, m=0, cin=0, abus, drw, ldz, ldc.
  - AND 0011, W2: s=1011, m=1, abus, drw, ldz.
  - INC 0100, W2: s=0000, m=0, cin=0, abus, drw, ldz, ldc.
  - LD 0101: W2 s=1010, m=1, abus, lar, long; W3 mbus, drw.
  - ST 0110: W2 s=1111, m=1, abus, lar, long; W3 s=1010, m=1, abus, memw.
  - JC 0111, W2: pcadd=c.
  - JZ 1000, W2: pcadd=z.
  - JMP 1001, W2: s=1111, m=1, abus, lpc.
  - STP 1110, W2: stop.
  - NOP 0000 and all other opcodes: no W2 strobes.
- Mode 001, memory write:
  - st0=0, W1: sbus, lar, short, stop, selctl; st0 then sets.
  - st0=1, W1: sbus, memw, arinc, short, stop, selctl.
- Mode 010, memory read:
  - st0=0, W1: as mode 001.
  - st0=1, W1: mbus, arinc, short, stop, selctl.
- Mode 011, register read:
  - W1: selctl, short, stop; sel_a=reg_idx, sel_b=reg_idx+1.
  - reg_idx advances by 2 and wraps to 0 after REG_N-2.
- Mode 100, register write:
  - W1: selctl, sbus, drw, short, stop; sel_a=reg_idx.
  - reg_idx advances by 1 and wraps REG_N-1 -> 0; st0 toggles on wrap.
- Modes 101/110/111: W1 short, stop only.
- Reset mid-instruction aborts immediately. Strobes drop asynchronously.

Optional Feature:
SINGLE_STEP_EN.
- Defined: input port step (1 bit) exists. In mode 000 with st0=1 and step=1, stop is asserted on the final beat of every instruction: W2 if long=0, else W3.
- Undefined: no step port; behaviour as above.

Decomposition:
- Package ctrl_pkg holds:
  - mode localparams: MODE_RUN, MODE_MEMW, MODE_MEMR, MODE_REGR, MODE_REGW;
  - opcode localparams;
  - ALU code constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_INC, ALU_PASS_A, ALU_PASS_B;
  - beat encodings W1/W2/W3.
- Sub-module beat_gen holds the beat register, halted flag, qd handling and short/long/stop sequencing. The decode logic stays in the top.

Test Plan:
- clr=1 mid-W3 of LD -> w=001, halted=1, all strobes 0 immediately.
- Mode 000: qd, PC load, qd, ADD -> W1 lir+pcinc; W2 s=1001, cin=1, drw, ldz, ldc; next beat W1.
- LD then ST -> three beats each; W3 drw+mbus for LD, memw for ST; JC with c=0 -> pcadd=0; c=1 -> pcadd=1.
- Mode 100, REG_N=4, five qd pulses -> sel_a 0,1,2,3,0; st0 toggles after the fourth write; each beat halts.
- Mode 011, REG_N=8 -> (sel_a,sel_b) = (0,1),(2,3),(4,5),(6,7),(0,1).
- SINGLE_STEP_EN, step=1, ADD,ADD -> halted after each W2; step=0 -> no halt until STP.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the sequencing controller
package ctrl_pkg;

    localparam logic [2:0] MODE_RUN  = 3'b000;
    localparam logic [2:0] MODE_MEMW = 3'b001;
    localparam logic [2:0] MODE_MEMR = 3'b010;
    localparam logic [2:0] MODE_REGR = 3'b011;
    localparam logic [2:0] MODE_REGW = 3'b100;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_INC = 4'b0100;
    localparam logic [3:0] OP_LD  = 4'b0101;
    localparam logic [3:0] OP_ST  = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_STP = 4'b1110;

    // 74181-style codes; the logic-mode pass codes route one operand straight through
    localparam logic [3:0] ALU_ADD    = 4'b1001;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b1011;
    localparam logic [3:0] ALU_INC    = 4'b0000;
    localparam logic [3:0] ALU_PASS_A = 4'b1111;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;

    typedef enum logic [2:0] {
        W1 = 3'b001,
        W2 = 3'b010,
        W3 = 3'b100
    } beat_t;

endpackage

// File: rtl/beat_gen.sv
// rtl/beat_gen.sv - beat register, run/halt flag and console start handling
module beat_gen
    import ctrl_pkg::*;
(
    input  logic       t3,
    input  logic       clr,
    input  logic       qd,
    input  logic [2:0] sw,
    input  logic       short_i,
    input  logic       long_i,
    input  logic       stop_i,
    output beat_t      beat,
    output logic       halted,
    output logic [2:0] mode,
    output logic       mode_chg
);

    beat_t      w_q, w_d;
    logic       halted_q, halted_d;
    logic [2:0] mode_q, mode_d;
    logic       start;

    always_ff @(posedge t3 or posedge clr) begin
        if (clr) begin
            w_q      <= W1;
            halted_q <= 1'b1;
            mode_q   <= MODE_RUN;
        end else begin
            w_q      <= w_d;
            halted_q <= halted_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        w_d      = w_q;
        halted_d = halted_q;
        mode_d   = mode_q;
        start    = qd && halted_q;
        mode_chg = start && (sw != mode_q);
        if (start) begin
            mode_d   = sw;
            halted_d = 1'b0;
        end else if (!halted_q) begin
            if (stop_i) begin
                halted_d = 1'b1;
            end
            case (w_q)
                W1:      w_d = short_i ? W1 : W2;
                W2:      w_d = long_i  ? W3 : W1;
                default: w_d = W1;
            endcase
        end
    end

    assign beat   = w_q;
    assign halted = halted_q;
    assign mode   = mode_q;

endmodule

// File: rtl/seq_ctrl_unit.sv
// rtl/seq_ctrl_unit.sv - hardwired controller top; SINGLE_STEP_EN adds the step input
module seq_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int REG_N  = 4,
    parameter int RSEL_W = 2
) (
    input  logic              t3,
    input  logic              clr,
    input  logic              qd,
    input  logic [2:0]        sw,
    input  logic [3:0]        ir,
    input  logic              c,
    input  logic              z,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [2:0]        w,
    output logic              st0,
    output logic              halted,
    output logic              drw,
    output logic              memw,
    output logic              lpc,
    output logic              lar,
    output logic              pcinc,
    output logic              pcadd,
    output logic              arinc,
    output logic              selctl,
    output logic              lir,
    output logic              ldz,
    output logic              ldc,
    output logic              cin,
    output logic              m,
    output logic              abus,
    output logic              sbus,
    output logic              mbus,
    output logic              short,
    output logic              long,
    output logic              stop,
    output logic [3:0]        s,
    output logic [RSEL_W-1:0] sel_a,
    output logic [RSEL_W-1:0] sel_b
);

    localparam logic [RSEL_W-1:0] IDX_LAST = RSEL_W'(REG_N - 1);

    beat_t             beat;
    logic [2:0]        mode;
    logic              mode_chg;
    logic              st0_q, st0_d;
    logic [RSEL_W-1:0] reg_idx_q, reg_idx_d;

    beat_gen u_beat_gen (
        .t3       (t3),
        .clr      (clr),
        .qd       (qd),
        .sw       (sw),
        .short_i  (short),
        .long_i   (long),
        .stop_i   (stop),
        .beat     (beat),
        .halted   (halted),
        .mode     (mode),
        .mode_chg (mode_chg)
    );

    always_ff @(posedge t3 or posedge clr) begin
        if (clr) begin
            st0_q     <= 1'b0;
            reg_idx_q <= '0;
        end else begin
            st0_q     <= st0_d;
            reg_idx_q <= reg_idx_d;
        end
    end

    always_comb begin
        st0_d     = st0_q;
        reg_idx_d = reg_idx_q;
        if (mode_chg) begin
            st0_d     = 1'b0;
            reg_idx_d = '0;
        end else if (!halted && beat == W1) begin
            case (mode)
                MODE_RUN, MODE_MEMW, MODE_MEMR: st0_d = 1'b1;
                MODE_REGR: reg_idx_d = reg_idx_q + RSEL_W'(2);
                MODE_REGW: begin
                    reg_idx_d = reg_idx_q + RSEL_W'(1);
                    if (reg_idx_q == IDX_LAST) begin
                        st0_d = ~st0_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        {drw, memw, lpc, lar, pcinc, pcadd, arinc, selctl, lir, ldz} = '0;
        {ldc, cin, m, abus, sbus, mbus, short, long, stop} = '0;
        s     = '0;
        sel_a = '0;
        sel_b = '0;
        // Everything is decoded only while running, so halt and async clear silence the datapath
        if (!halted) begin
            case (mode)
                MODE_RUN: begin
                    if (!st0_q) begin
                        if (beat == W1) {sbus, lpc, short, stop} = '1;
                    end else begin
                        case (beat)
                            W1: {lir, pcinc} = '1;
                            W2: begin
                                case (ir)
                                    OP_ADD: begin s = ALU_ADD; {cin, abus, drw, ldz, ldc} = '1; end
                                    OP_SUB: begin s = ALU_SUB; {abus, drw, ldz, ldc} = '1; end
                                    OP_AND: begin s = ALU_AND; {m, abus, drw, ldz} = '1; end
                                    OP_INC: begin s = ALU_INC; {abus, drw, ldz, ldc} = '1; end
                                    OP_LD:  begin s = ALU_PASS_B; {m, abus, lar, long} = '1; end
                                    OP_ST:  begin s = ALU_PASS_A; {m, abus, lar, long} = '1; end
                                    OP_JC:  pcadd = c;
                                    OP_JZ:  pcadd = z;
                                    OP_JMP: begin s = ALU_PASS_A; {m, abus, lpc} = '1; end
                                    OP_STP: stop = 1'b1;
                                    default: ;
                                endcase
                            end
                            W3: begin
                                case (ir)
                                    OP_LD: {mbus, drw} = '1;
                                    OP_ST: begin s = ALU_PASS_B; {m, abus, memw} = '1; end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
`ifdef SINGLE_STEP_EN
                        if (step && ((beat == W2 && !long) || beat == W3)) stop = 1'b1;
`endif
                    end
                end
                MODE_MEMW, MODE_MEMR: begin
                    if (beat == W1) begin
                        {short, stop, selctl} = '1;
                        if (!st0_q)                {sbus, lar} = '1;
                        else if (mode == MODE_MEMW) {sbus, memw, arinc} = '1;
                        else                       {mbus, arinc} = '1;
                    end
                end
                MODE_REGR: begin
                    if (beat == W1) begin
                        {selctl, short, stop} = '1;
                        sel_a = reg_idx_q;
                        sel_b = reg_idx_q + RSEL_W'(1);
                    end
                end
                MODE_REGW: begin
                    if (beat == W1) begin
                        {selctl, sbus, drw, short, stop} = '1;
                        sel_a = reg_idx_q;
                    end
                end
                default: begin
                    if (beat == W1) {short, stop} = '1;
                end
            endcase
        end
    end

    assign w   = beat;
    assign st0 = st0_q;

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// tb/tb_seq_ctrl_unit.sv - directed scoreboard bench for seq_ctrl_unit (REG_N=4 and REG_N=8)
module tb_seq_ctrl_unit;

    localparam logic [18:0] DRW = 19'd1 << 18, MEMW = 19'd1 << 17, LPC = 19'd1 << 16;
    localparam logic [18:0] LAR = 19'd1 << 15, PCINC = 19'd1 << 14, PCADD = 19'd1 << 13;
    localparam logic [18:0] ARINC = 19'd1 << 12, SELCTL = 19'd1 << 11, LIR = 19'd1 << 10;
    localparam logic [18:0] LDZ = 19'd1 << 9, LDC = 19'd1 << 8, CIN = 19'd1 << 7;
    localparam logic [18:0] M = 19'd1 << 6, ABUS = 19'd1 << 5, SBUS = 19'd1 << 4;
    localparam logic [18:0] MBUS = 19'd1 << 3, SHORT = 19'd1 << 2, LONG = 19'd1 << 1, STOP = 19'd1;
    localparam logic [2:0]  B1 = 3'b001, B2 = 3'b010, B3 = 3'b100;

    logic t3, clr, qd, c, z;
    logic [2:0] sw;
    logic [3:0] ir;
`ifdef SINGLE_STEP_EN
    logic step;
`endif

    logic [2:0]  w4, w8;
    logic        st04, st08, h4, h8;
    logic [18:0] str4, str8;
    logic [3:0]  s4, s8;
    logic [1:0]  sa4, sb4;
    logic [2:0]  sa8, sb8;

    int n_assert = 0;
    int n_fail   = 0;
    logic [35:0] exp_q[$];
    string       tag_q[$];

    seq_ctrl_unit #(.REG_N(4), .RSEL_W(2)) u4 (
        .t3(t3), .clr(clr), .qd(qd), .sw(sw), .ir(ir), .c(c), .z(z),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .w(w4), .st0(st04), .halted(h4),
        .drw(str4[18]), .memw(str4[17]), .lpc(str4[16]), .lar(str4[15]), .pcinc(str4[14]),
        .pcadd(str4[13]), .arinc(str4[12]), .selctl(str4[11]), .lir(str4[10]), .ldz(str4[9]),
        .ldc(str4[8]), .cin(str4[7]), .m(str4[6]), .abus(str4[5]), .sbus(str4[4]),
        .mbus(str4[3]), .short(str4[2]), .long(str4[1]), .stop(str4[0]),
        .s(s4), .sel_a(sa4), .sel_b(sb4)
    );

    seq_ctrl_unit #(.REG_N(8), .RSEL_W(3)) u8 (
        .t3(t3), .clr(clr), .qd(qd), .sw(sw), .ir(ir), .c(c), .z(z),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .w(w8), .st0(st08), .halted(h8),
        .drw(str8[18]), .memw(str8[17]), .lpc(str8[16]), .lar(str8[15]), .pcinc(str8[14]),
        .pcadd(str8[13]), .arinc(str8[12]), .selctl(str8[11]), .lir(str8[10]), .ldz(str8[9]),
        .ldc(str8[8]), .cin(str8[7]), .m(str8[6]), .abus(str8[5]), .sbus(str8[4]),
        .mbus(str8[3]), .short(str8[2]), .long(str8[1]), .stop(str8[0]),
        .s(s8), .sel_a(sa8), .sel_b(sb8)
    );

    initial t3 = 1'b0;
    always #5 t3 = ~t3;

    function automatic logic [35:0] pk(input logic [2:0] bw, input logic bst0, input logic bh,
                                       input logic [3:0] bs, input logic [3:0] bsa,
                                       input logic [3:0] bsb, input logic [18:0] bstr);
        return {bw, bst0, bh, bs, bsa, bsb, bstr};
    endfunction

    function automatic logic [35:0] idle(input logic bst0);
        return pk(B1, bst0, 1'b1, 4'd0, 4'd0, 4'd0, 19'd0);
    endfunction

    function automatic logic [35:0] run(input logic [2:0] bw, input logic bst0,
                                        input logic [3:0] bs, input logic [18:0] bstr);
        return pk(bw, bst0, 1'b0, bs, 4'd0, 4'd0, bstr);
    endfunction

    task automatic tick();
        @(negedge t3);
    endtask

    task automatic go();
        qd = 1'b1;
        tick();
        qd = 1'b0;
    endtask

    task automatic chk(input string tag, input bit use8, input logic [35:0] e);
        logic [35:0] o, x;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        if (use8) o = pk(w8, st08, h8, s8, {1'b0, sa8}, {1'b0, sb8}, str8);
        else      o = pk(w4, st04, h4, s4, {2'b0, sa4}, {2'b0, sb4}, str4);
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        n_assert++;
        assert (o === x) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, o, x);
        end
    endtask

    initial begin
        clr = 1'b0; qd = 1'b0; sw = 3'b000; ir = 4'b0000; c = 1'b0; z = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        #2 clr = 1'b1;
        tick();
        chk("reset", 0, idle(1'b0));
        qd = 1'b1;
        tick();
        chk("clr_beats_qd", 0, idle(1'b0));
        clr = 1'b0;

        go();
        chk("pc_load", 0, run(B1, 1'b0, 4'd0, SBUS | LPC | SHORT | STOP));
        tick();
        chk("pc_load_halt", 0, idle(1'b1));

        ir = 4'b0001; go();
        chk("add_w1", 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
        chk("add_w2", 0, run(B2, 1'b1, 4'b1001, CIN | ABUS | DRW | LDZ | LDC)); tick();
        ir = 4'b0101;
        chk("ld_w1", 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
        chk("ld_w2", 0, run(B2, 1'b1, 4'b1010, M | ABUS | LAR | LONG)); tick();
        chk("ld_w3", 0, run(B3, 1'b1, 4'd0, MBUS | DRW)); tick();
        ir = 4'b0110;
        chk("st_w1", 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
        chk("st_w2", 0, run(B2, 1'b1, 4'b1111, M | ABUS | LAR | LONG)); tick();
        chk("st_w3", 0, run(B3, 1'b1, 4'b1010, M | ABUS | MEMW)); tick();
        ir = 4'b0111; c = 1'b0;
        chk("jc0_w1", 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
        chk("jc0_w2", 0, run(B2, 1'b1, 4'd0, 19'd0)); tick();
        c = 1'b1;
        chk("jc1_w1", 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
        chk("jc1_w2", 0, run(B2, 1'b1, 4'd0, PCADD)); tick();
        ir = 4'b1001; qd = 1'b1; sw = 3'b001;
        chk("jmp_w1", 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
        qd = 1'b0;
        chk("jmp_w2_qd_ignored", 0, run(B2, 1'b1, 4'b1111, M | ABUS | LPC)); tick();
        sw = 3'b000; ir = 4'b1110;
        chk("stp_w1", 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
        chk("stp_w2", 0, run(B2, 1'b1, 4'd0, STOP)); tick();
        chk("stp_halt", 0, idle(1'b1));

        ir = 4'b0101; go(); tick(); tick();
        chk("ld_w3_again", 0, run(B3, 1'b1, 4'd0, MBUS | DRW));
        clr = 1'b1;
        chk("clr_async", 0, idle(1'b0));
        tick();
        clr = 1'b0;

        sw = 3'b100;
        for (int i = 0; i < 5; i++) begin
            go();
            chk($sformatf("regw_%0d", i), 0,
                pk(B1, (i == 4), 1'b0, 4'd0, 4'(i % 4), 4'd0, SELCTL | SBUS | DRW | SHORT | STOP));
            tick();
            if (i == 3) chk("regw_wrap_st0", 0, idle(1'b1));
        end

        sw = 3'b011;
        for (int i = 0; i < 5; i++) begin
            go();
            chk($sformatf("regr_%0d", i), 1,
                pk(B1, 1'b0, 1'b0, 4'd0, 4'((2 * i) % 8), 4'((2 * i + 1) % 8), SELCTL | SHORT | STOP));
            tick();
        end

        sw = 3'b001;
        go(); chk("memw_addr", 0, run(B1, 1'b0, 4'd0, SBUS | LAR | SHORT | STOP | SELCTL)); tick();
        go(); chk("memw_data", 0, run(B1, 1'b1, 4'd0, SBUS | MEMW | ARINC | SHORT | STOP | SELCTL)); tick();
        sw = 3'b010;
        go(); chk("memr_addr", 0, run(B1, 1'b0, 4'd0, SBUS | LAR | SHORT | STOP | SELCTL)); tick();
        go(); chk("memr_data", 0, run(B1, 1'b1, 4'd0, MBUS | ARINC | SHORT | STOP | SELCTL)); tick();
        sw = 3'b111;
        go(); chk("mode7", 0, run(B1, 1'b0, 4'd0, SHORT | STOP)); tick();
        chk("mode7_halt", 0, idle(1'b0));

`ifdef SINGLE_STEP_EN
        sw = 3'b000;
        go(); tick();
        step = 1'b1; ir = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            go();
            chk($sformatf("step_add_w1_%0d", i), 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
            chk($sformatf("step_add_w2_%0d", i), 0,
                run(B2, 1'b1, 4'b1001, CIN | ABUS | DRW | LDZ | LDC | STOP)); tick();
            chk($sformatf("step_halt_%0d", i), 0, idle(1'b1));
        end
        step = 1'b0;
        go();
        chk("free_add_w1", 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
        chk("free_add_w2", 0, run(B2, 1'b1, 4'b1001, CIN | ABUS | DRW | LDZ | LDC)); tick();
        ir = 4'b1110;
        chk("free_stp_w1", 0, run(B1, 1'b1, 4'd0, LIR | PCINC)); tick();
        chk("free_stp_w2", 0, run(B2, 1'b1, 4'd0, STOP)); tick();
        chk("free_stp_halt", 0, idle(1'b1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
